// File: rtl/lis_mem_arbiter_pkg.sv
// Shared definitions for the LIS memory-port arbiter: FSM encodings and quota helpers.
package lis_mem_arbiter_pkg;

    typedef enum logic {
        ARB_S_CPU = 1'b0,
        ARB_S_DMA = 1'b1
    } arb_state_t;

    localparam int QUOTA_W = 4;

    // Saturating increment: the counter never climbs past the CPU quota.
    function automatic logic [QUOTA_W-1:0] quota_inc(
        input logic [QUOTA_W-1:0] q,
        input logic [QUOTA_W-1:0] lim
    );
        return (q >= lim) ? lim : q + 4'd1;
    endfunction

endpackage

// File: rtl/lis_mem_arbiter_if.sv
// CPU, DMA and memory-side signals of the shared byte-wide memory port.
interface lis_mem_arbiter_if #(
    parameter int AW = 32
);
    logic          cpu_ce;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_out;
    logic          cpu_we;
    logic [7:0]    cpu_in;

    logic          dma_req;
    logic [AW-1:0] dma_address;
    logic [7:0]    dma_out;
    logic          dma_we;
    logic          dma_ack;
    logic          dma_valid;
    logic [7:0]    dma_in;

    logic [AW-1:0] mem_address;
    logic [7:0]    mem_out;
    logic          mem_we;
    logic [7:0]    mem_in;

    modport slave (
        output cpu_ce, cpu_in, dma_ack, dma_valid, dma_in, mem_address, mem_out, mem_we,
        input  cpu_address, cpu_out, cpu_we, dma_req, dma_address, dma_out, dma_we, mem_in
    );

    modport master (
        input  cpu_ce, cpu_in, dma_ack, dma_valid, dma_in, mem_address, mem_out, mem_we,
        output cpu_address, cpu_out, cpu_we, dma_req, dma_address, dma_out, dma_we, mem_in
    );

endinterface

// File: rtl/lis_mem_arbiter.sv
// Cycle-stealing arbiter: the CPU is frozen for one cycle per DMA slot and its
// displaced read byte is replayed afterwards so the stall is transparent.
module lis_mem_arbiter
    import lis_mem_arbiter_pkg::*;
#(
    parameter int CPU_SLOTS = 3,
    parameter int AW        = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    lis_mem_arbiter_if.slave bus
);

    localparam logic [QUOTA_W-1:0] SLOTS = 4'(CPU_SLOTS);

    arb_state_t         state_reg;
    logic [QUOTA_W-1:0] quota_reg;
    logic [QUOTA_W-1:0] quota_next;
    logic [7:0]         hold_reg;
    logic               replay_reg;
    logic               rd_pend_reg;

    logic               is_dma;
    logic               grant;
    logic [AW-1:0]      mem_address_mux;
    logic [7:0]         mem_out_mux;
    logic               mem_we_mux;
    logic [7:0]         cpu_in_mux;

    assign is_dma     = (state_reg == ARB_S_DMA);
    assign quota_next = quota_inc(quota_reg, SLOTS);

    // Grant once the cycle in progress completes the CPU's quota of enabled cycles,
    // giving one DMA slot every CPU_SLOTS+1 cycles under a held request.
    assign grant = bus.dma_req && (quota_next == SLOTS);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= ARB_S_CPU;
            quota_reg   <= '0;
            hold_reg    <= '0;
            replay_reg  <= 1'b0;
            rd_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                ARB_S_CPU: begin
                    quota_reg   <= quota_next;
                    replay_reg  <= 1'b0;
                    rd_pend_reg <= 1'b0;
                    if (grant) begin
                        state_reg <= ARB_S_DMA;
                    end
                end
                ARB_S_DMA: begin
                    // mem_in now carries the byte for the CPU's last address; keep it for replay.
                    hold_reg    <= bus.mem_in;
                    replay_reg  <= 1'b1;
                    quota_reg   <= '0;
                    rd_pend_reg <= ~bus.dma_we;
                    state_reg   <= ARB_S_CPU;
                end
                default: begin
                    state_reg <= ARB_S_CPU;
                end
            endcase
        end
    end

    assign mem_address_mux = is_dma ? bus.dma_address : bus.cpu_address;
    assign mem_we_mux      = is_dma ? bus.dma_we      : bus.cpu_we;

    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
        assign mem_out_mux[gi] = is_dma     ? bus.dma_out[gi] : bus.cpu_out[gi];
        assign cpu_in_mux[gi]  = replay_reg ? hold_reg[gi]    : bus.mem_in[gi];
    end

    assign bus.mem_address = mem_address_mux;
    assign bus.mem_out     = mem_out_mux;
    assign bus.mem_we      = mem_we_mux;
    assign bus.cpu_in      = cpu_in_mux;
    assign bus.cpu_ce      = ~is_dma;
    assign bus.dma_ack     = is_dma;
    assign bus.dma_valid   = rd_pend_reg;
    assign bus.dma_in      = bus.mem_in;

endmodule

// File: tb/tb_lis_mem_arbiter.sv
// Bench for lis_mem_arbiter: behavioural memory, stimulus table, DMA read scoreboard.
module tb_lis_mem_arbiter;

    localparam int AW = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic load_mem = 1'b1;

    always #5 clock = ~clock;

    lis_mem_arbiter_if #(.AW(AW)) bus ();

    lis_mem_arbiter #(.CPU_SLOTS(3), .AW(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [7:0] pat(input logic [11:0] a);
        case (a)
            12'h100: return 8'h5A;
            12'h010: return 8'hC3;
            12'h200: return 8'h11;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    logic [7:0] mem [0:4095];

    always @(posedge clock) begin
        if (load_mem) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
        end else begin
            bus.mem_in <= mem[bus.mem_address[11:0]];
            if (bus.mem_we) mem[bus.mem_address[11:0]] <= bus.mem_out;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q [$];
    int w20 = 0;
    int w30 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read data is due the cycle after a read ack; pop before pushing this cycle's ack.
    task automatic monitor();
        logic [7:0] e;
        if (bus.dma_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL dma_valid_spurious: dma_valid=1 with nothing outstanding at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                if (bus.dma_in !== e) begin
                    errors++;
                    $display("FAIL dma_in: got %0h expected %0h at %0t", bus.dma_in, e, $time);
                end
            end
        end else if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL dma_valid_missing: dma_valid=0 with read outstanding at %0t", $time);
            sb_q.delete();
        end
        if (bus.dma_ack && !bus.dma_we) sb_q.push_back(pat(bus.dma_address[11:0]));
    endtask

    task automatic drive(input logic rn, input logic [31:0] ca, input logic [7:0] co, input logic cw,
                         input logic dr, input logic [31:0] da, input logic [7:0] dd, input logic dw);
        @(negedge clock);
        reset_n         = rn;
        bus.cpu_address = ca;
        bus.cpu_out     = co;
        bus.cpu_we      = cw;
        bus.dma_req     = dr;
        bus.dma_address = da;
        bus.dma_out     = dd;
        bus.dma_we      = dw;
        #1;
    endtask

    task automatic count_writes();
        if (bus.mem_we && bus.mem_address == 32'h20) w20++;
        if (bus.mem_we && bus.mem_address == 32'h30) w30++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 32'h400, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
            monitor();
        end
    endtask

    typedef struct {
        logic        dma_req;
        logic        exp_ce;
        logic        exp_ack;
        logic        exp_valid;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Held DMA read request from reset: grants at cycles 3, 7, 11; data the cycle after.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h400};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h400};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h400};

        bus.cpu_address = '0; bus.cpu_out = '0; bus.cpu_we = 1'b0;
        bus.dma_req = 1'b0; bus.dma_address = '0; bus.dma_out = '0; bus.dma_we = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("reset_cpu_ce", {31'b0, bus.cpu_ce}, 32'd1);
        chk("reset_dma_ack", {31'b0, bus.dma_ack}, 32'd0);
        chk("reset_dma_valid", {31'b0, bus.dma_valid}, 32'd0);
        load_mem = 1'b0;

        // No DMA: random CPU traffic passes straight through
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h400 + 32'($urandom_range(0, 1023)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'b0, 32'h0, 8'h00, 1'b0);
            chk("t1_cpu_ce", {31'b0, bus.cpu_ce}, 32'd1);
            chk("t1_mem_address", bus.mem_address, bus.cpu_address);
            chk("t1_mem_out", {24'b0, bus.mem_out}, {24'b0, bus.cpu_out});
            chk("t1_mem_we", {31'b0, bus.mem_we}, {31'b0, bus.cpu_we});
            chk("t1_cpu_in", {24'b0, bus.cpu_in}, {24'b0, bus.mem_in});
            monitor();
        end

        // Periodic grants from reset
        drive(1'b0, 32'h400, 8'h00, 1'b0, 1'b0, 32'h100, 8'h00, 1'b0);
        drive(1'b0, 32'h400, 8'h00, 1'b0, 1'b0, 32'h100, 8'h00, 1'b0);
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 32'h400, 8'h00, 1'b0, tbl[i].dma_req, 32'h100, 8'h00, 1'b0);
            $display("vec %0d: ce=%0b ack=%0b valid=%0b addr=%0h", i, bus.cpu_ce, bus.dma_ack,
                     bus.dma_valid, bus.mem_address);
            chk($sformatf("t2_cpu_ce[%0d]", i), {31'b0, bus.cpu_ce}, {31'b0, tbl[i].exp_ce});
            chk($sformatf("t2_dma_ack[%0d]", i), {31'b0, bus.dma_ack}, {31'b0, tbl[i].exp_ack});
            chk($sformatf("t2_dma_valid[%0d]", i), {31'b0, bus.dma_valid}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("t2_mem_address[%0d]", i), bus.mem_address, tbl[i].exp_addr);
            monitor();
        end

        // CPU read displaced by a DMA read is replayed
        idle(3);
        drive(1'b1, 32'h10, 8'h00, 1'b0, 1'b1, 32'h200, 8'h00, 1'b0);
        chk("t4_pre_ack", {31'b0, bus.dma_ack}, 32'd0);
        monitor();
        drive(1'b1, 32'h10, 8'h00, 1'b0, 1'b1, 32'h200, 8'h00, 1'b0);
        chk("t4_ack", {31'b0, bus.dma_ack}, 32'd1);
        chk("t4_ce_low", {31'b0, bus.cpu_ce}, 32'd0);
        chk("t4_mem_address", bus.mem_address, 32'h200);
        monitor();
        drive(1'b1, 32'h10, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("t4_ce_back", {31'b0, bus.cpu_ce}, 32'd1);
        chk("t4_cpu_in_replay", {24'b0, bus.cpu_in}, 32'hC3);
        chk("t4_dma_in", {24'b0, bus.dma_in}, 32'h11);
        monitor();
        $display("t4: cpu_in=%0h dma_in=%0h", bus.cpu_in, bus.dma_in);

        // CPU write collides with DMA write: each issued exactly once
        idle(3);
        drive(1'b1, 32'h400, 8'h00, 1'b0, 1'b1, 32'h30, 8'h99, 1'b1);
        count_writes(); monitor();
        drive(1'b1, 32'h20, 8'h77, 1'b1, 1'b1, 32'h30, 8'h99, 1'b1);
        chk("t5_ack", {31'b0, bus.dma_ack}, 32'd1);
        chk("t5_dma_we", {31'b0, bus.mem_we}, 32'd1);
        chk("t5_dma_addr", bus.mem_address, 32'h30);
        chk("t5_dma_data", {24'b0, bus.mem_out}, 32'h99);
        count_writes(); monitor();
        drive(1'b1, 32'h20, 8'h77, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("t5_cpu_ce", {31'b0, bus.cpu_ce}, 32'd1);
        chk("t5_cpu_we", {31'b0, bus.mem_we}, 32'd1);
        chk("t5_cpu_addr", bus.mem_address, 32'h20);
        chk("t5_cpu_data", {24'b0, bus.mem_out}, 32'h77);
        chk("t5_no_valid", {31'b0, bus.dma_valid}, 32'd0);
        count_writes(); monitor();
        // Request raised while quota is short, then withdrawn: never granted
        drive(1'b1, 32'h400, 8'h00, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0);
        count_writes(); monitor();
        chk("t5_write_20_once", 32'(w20), 32'd1);
        chk("t5_write_30_once", 32'(w30), 32'd1);
        chk("t5_mem_20", {24'b0, mem[12'h20]}, 32'h77);
        chk("t5_mem_30", {24'b0, mem[12'h30]}, 32'h99);
        $display("t5: writes 0x20=%0d 0x30=%0d", w20, w30);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h400, 8'h00, 1'b0, 1'b0, 32'h100, 8'h00, 1'b0);
            chk($sformatf("drop_no_ack[%0d]", i), {31'b0, bus.dma_ack}, 32'd0);
            monitor();
        end
        // Saturated quota: a fresh request is granted the next cycle
        drive(1'b1, 32'h400, 8'h00, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0);
        chk("sat_pre_ack", {31'b0, bus.dma_ack}, 32'd0);
        monitor();
        // Reset lands while this DMA read is on the bus
        drive(1'b0, 32'h400, 8'h00, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0);
        chk("sat_ack", {31'b0, bus.dma_ack}, 32'd1);
        monitor();
        sb_q.delete();
        drive(1'b1, 32'h400, 8'h00, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0);
        chk("t6_cpu_ce", {31'b0, bus.cpu_ce}, 32'd1);
        chk("t6_dma_ack", {31'b0, bus.dma_ack}, 32'd0);
        chk("t6_dma_valid", {31'b0, bus.dma_valid}, 32'd0);
        monitor();
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'h400, 8'h00, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0);
            chk($sformatf("t6_regrant[%0d]", i), {31'b0, bus.dma_ack}, (i == 3) ? 32'd1 : 32'd0);
            monitor();
        end
        drive(1'b1, 32'h400, 8'h00, 1'b0, 1'b0, 32'h100, 8'h00, 1'b0);
        monitor();
        $display("t6: re-grant sequence complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
